// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared CPU control-field offsets, default widths and stage occupancy states
package pipe_stage_reg_pkg;
  localparam int DATA_W_DEF   = 128;
  localparam int CTRL_W_DEF   = 16;
  localparam int CNT_W_DEF    = 16;
  localparam int REG_WE_BIT   = 0;
  localparam int MEM_WE_BIT   = 1;
  localparam int MEM_RE_BIT   = 2;
  localparam int PC_SEL_LSB   = 3;
  localparam int PC_SEL_W     = 2;
  localparam int ALU_CTRL_LSB = 5;
  localparam int ALU_CTRL_W   = 4;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} stage_state_t;
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear and async active-low reset
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage (skid or single entry) with flush, zeroed bubble control and stall/bubble counters
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic              vld;
  logic              rdy;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  if (SKID != 0) begin : g_skid
    stage_state_t      state, state_nx;
    logic              rdy_q, in_fire, out_fire;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    assign in_fire  = in_valid & rdy_q;
    assign out_fire = (state != EMPTY) & out_ready;
    always_comb begin
      state_nx = flush ? EMPTY
               : (state == FULL) ? (out_fire ? ONE : FULL)
               : (state == ONE)  ? (in_fire ? (out_fire ? ONE : FULL) : (out_fire ? EMPTY : ONE))
               : (in_fire ? ONE : EMPTY);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state     <= EMPTY;
        rdy_q     <= 1'b1;
        main_ctrl <= '0;
        main_data <= '0;
        skid_ctrl <= '0;
        skid_data <= '0;
      end else begin
        state <= state_nx;
        rdy_q <= state_nx != FULL;
        if (!flush && in_fire && (state == EMPTY || out_fire)) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end else if (!flush && out_fire && state == FULL) begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
        end
        if (!flush && in_fire && !out_fire && state == ONE) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
    assign vld    = state != EMPTY;
    assign rdy    = rdy_q;
    assign ctrl_q = main_ctrl;
    assign data_q = main_data;
  end else begin : g_single
    logic              v, in_fire, out_fire;
    logic [CTRL_W-1:0] e_ctrl;
    logic [DATA_W-1:0] e_data;
    assign rdy      = out_ready | ~v;
    assign in_fire  = in_valid & rdy;
    assign out_fire = v & out_ready;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v      <= 1'b0;
        e_ctrl <= '0;
        e_data <= '0;
      end else begin
        v <= !flush && (in_fire || (v && !out_fire));
        if (!flush && in_fire) begin
          e_ctrl <= in_ctrl;
          e_data <= in_data;
        end
      end
    assign vld    = v;
    assign ctrl_q = e_ctrl;
    assign data_q = e_data;
  end
  assign in_ready  = rdy;
  assign out_valid = vld;
  assign out_ctrl  = ctrl_q & {CTRL_W{vld}};
  assign out_data  = data_q;
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(vld & ~out_ready), .cnt(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_bubble (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(~vld & out_ready), .cnt(bubble_cnt)
  );
endmodule
